// File: rtl/ofs_fim_axis_arb_pkg.sv
// ---------------------------------------------------------------------------
// ofs_fim_axis_arb_pkg
// Shared types and helpers for the two-input packet-aware AXIS arbiter.
//   t_arb_state : arbiter lock state (IDLE = free to choose, BUSY = locked)
//   t_port_idx  : index of one of the two sink ports
//   PRIO_RR / PRIO_FIXED : values of the PRIO_MODE parameter
//   arb_pick()  : the IDLE-state port selection rule
// ---------------------------------------------------------------------------
package ofs_fim_axis_arb_pkg;

    typedef enum logic {
        IDLE = 1'b0,
        BUSY = 1'b1
    } t_arb_state;

    typedef logic t_port_idx;

    localparam int PRIO_RR    = 0;
    localparam int PRIO_FIXED = 1;

    // With no valid port the choice is the port that did not win last time;
    // the data path follows it but m_tvalid is low, so it is only a default.
    function automatic t_port_idx arb_pick(input logic      v0,
                                           input logic      v1,
                                           input t_port_idx last_gnt,
                                           input int        mode);
        t_port_idx pick;
        pick = ~last_gnt;
        if (mode == PRIO_FIXED) begin
            if (v0)      pick = 1'b0;
            else if (v1) pick = 1'b1;
        end else begin
            if (v0 && !v1)      pick = 1'b0;
            else if (v1 && !v0) pick = 1'b1;
        end
        return pick;
    endfunction

endpackage

// File: rtl/ofs_fim_axis_arb_skid.sv
// ---------------------------------------------------------------------------
// ofs_fim_axis_arb_skid
// Generic one-entry skid register for a valid/ready stream. o_ready comes
// straight from a flop, so there is no combinational path i_ready -> o_ready,
// while a second holding register keeps one beat per clock.
//   clk, rst          : clock, synchronous active-high reset (empties stage)
//   i_valid/o_ready/i_data : upstream side
//   o_valid/i_ready/o_data : downstream side
// Handshake: a beat moves when valid and ready are both high on a rising
// edge; a presented valid is held with stable data until it is accepted.
// ---------------------------------------------------------------------------
module ofs_fim_axis_arb_skid #(
    parameter int W = 8
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         i_valid,
    output logic         o_ready,
    input  logic [W-1:0] i_data,
    output logic         o_valid,
    input  logic         i_ready,
    output logic [W-1:0] o_data
);

    logic         r_out_valid;
    logic [W-1:0] r_out_data;
    logic         r_skid_valid;
    logic [W-1:0] r_skid_data;

    assign o_ready = ~r_skid_valid;
    assign o_valid = r_out_valid;
    assign o_data  = r_out_data;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_out_valid  <= 1'b0;
            r_out_data   <= '0;
            r_skid_valid <= 1'b0;
            r_skid_data  <= '0;
        end else if (!r_out_valid || i_ready) begin
            // Output register is free this cycle: drain the skid first.
            if (r_skid_valid) begin
                r_out_data   <= r_skid_data;
                r_out_valid  <= 1'b1;
                r_skid_valid <= 1'b0;
            end else begin
                r_out_data  <= i_data;
                r_out_valid <= i_valid;
            end
        end else if (i_valid && !r_skid_valid) begin
            // Output stalled but we already advertised ready: park the beat.
            r_skid_data  <= i_data;
            r_skid_valid <= 1'b1;
        end
    end

endmodule

// File: rtl/ofs_fim_axis_arb2.sv
// ---------------------------------------------------------------------------
// ofs_fim_axis_arb2
// Two-input packet-aware AXI-Stream arbiter merging two PCIe SS TLP streams
// onto one source port. A grant is held from the first beat of a packet until
// its tlast beat is accepted; back-to-back packets pass without bubbles.
// Parameters: TDATA_WIDTH, TUSER_WIDTH, PRIO_MODE (0 round-robin, 1 fixed,
// port 0 highest).
// Ports:
//   clk, rst                      : clock, synchronous active-high reset
//   s0_* / s1_*                   : sink ports (tvalid/tready/tdata/tkeep/
//                                   tlast/tuser_vendor)
//   m_*                           : source port
//   m_src                         : port currently driving the source
//   o_dbg_state                   : arbiter state (0 IDLE, 1 BUSY)
// Handshake: a beat transfers on a rising edge where tvalid and tready are
// both high; the grant never changes while a presented beat is pending.
// Build option: OFS_FIM_AXIS_ARB2_OUTREG_EN inserts a registered skid stage
// between the mux and the m_* ports (1 cycle latency, full throughput).
// ---------------------------------------------------------------------------
module ofs_fim_axis_arb2
    import ofs_fim_axis_arb_pkg::*;
#(
    parameter int TDATA_WIDTH = 512,
    parameter int TUSER_WIDTH = 10,
    parameter int PRIO_MODE   = 0
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     s0_tvalid,
    output logic                     s0_tready,
    input  logic [TDATA_WIDTH-1:0]   s0_tdata,
    input  logic [TDATA_WIDTH/8-1:0] s0_tkeep,
    input  logic                     s0_tlast,
    input  logic [TUSER_WIDTH-1:0]   s0_tuser_vendor,
    input  logic                     s1_tvalid,
    output logic                     s1_tready,
    input  logic [TDATA_WIDTH-1:0]   s1_tdata,
    input  logic [TDATA_WIDTH/8-1:0] s1_tkeep,
    input  logic                     s1_tlast,
    input  logic [TUSER_WIDTH-1:0]   s1_tuser_vendor,
    output logic                     m_tvalid,
    input  logic                     m_tready,
    output logic [TDATA_WIDTH-1:0]   m_tdata,
    output logic [TDATA_WIDTH/8-1:0] m_tkeep,
    output logic                     m_tlast,
    output logic [TUSER_WIDTH-1:0]   m_tuser_vendor,
    output logic                     m_src,
    output logic                     o_dbg_state
);

    localparam int KW = TDATA_WIDTH / 8;

    t_arb_state r_state;
    t_port_idx  r_gnt;
    t_port_idx  r_last_gnt;

    t_port_idx               w_sel;
    logic                    w_vld;
    logic                    w_rdy;
    logic                    w_fire;
    logic [TDATA_WIDTH-1:0]  w_data;
    logic [KW-1:0]           w_keep;
    logic                    w_last;
    logic [TUSER_WIDTH-1:0]  w_user;

    // Port selection: free choice in IDLE, locked grant in BUSY.
    always_comb begin
        w_sel = (r_state == BUSY) ? r_gnt
                                  : arb_pick(s0_tvalid, s1_tvalid, r_last_gnt, PRIO_MODE);
        if (w_sel == 1'b1) begin
            w_vld  = s1_tvalid & ~rst;
            w_data = s1_tdata;
            w_keep = s1_tkeep;
            w_last = s1_tlast;
            w_user = s1_tuser_vendor;
        end else begin
            w_vld  = s0_tvalid & ~rst;
            w_data = s0_tdata;
            w_keep = s0_tkeep;
            w_last = s0_tlast;
            w_user = s0_tuser_vendor;
        end
    end

    assign w_fire    = w_vld & w_rdy;
    assign s0_tready = ~rst & (w_sel == 1'b0) & w_rdy;
    assign s1_tready = ~rst & (w_sel == 1'b1) & w_rdy;
    assign o_dbg_state = r_state;

    // Lock whenever a beat is presented but the packet does not finish this
    // cycle; that also covers a stalled first beat, so the grant cannot move
    // while tvalid is pending.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state    <= IDLE;
            r_gnt      <= 1'b0;
            r_last_gnt <= 1'b1;
        end else begin
            case (r_state)
                IDLE: begin
                    if (w_vld) begin
                        if (w_fire && w_last) begin
                            r_last_gnt <= w_sel;
                        end else begin
                            r_state <= BUSY;
                            r_gnt   <= w_sel;
                        end
                    end
                end
                BUSY: begin
                    if (w_fire && w_last) begin
                        r_state    <= IDLE;
                        r_last_gnt <= r_gnt;
                    end
                end
                default: r_state <= IDLE;
            endcase
        end
    end

`ifdef OFS_FIM_AXIS_ARB2_OUTREG_EN
    localparam int PW = 1 + TUSER_WIDTH + 1 + KW + TDATA_WIDTH;

    logic [PW-1:0] w_skid_in;
    logic [PW-1:0] w_skid_out;
    logic          w_skid_vld;

    assign w_skid_in = {w_sel, w_user, w_last, w_keep, w_data};

    ofs_fim_axis_arb_skid #(
        .W (PW)
    ) u_skid (
        .clk     (clk),
        .rst     (rst),
        .i_valid (w_vld),
        .o_ready (w_rdy),
        .i_data  (w_skid_in),
        .o_valid (w_skid_vld),
        .i_ready (m_tready),
        .o_data  (w_skid_out)
    );

    assign m_tvalid       = w_skid_vld & ~rst;
    assign m_src          = w_skid_out[PW-1] & ~rst;
    assign m_tuser_vendor = w_skid_out[PW-2 -: TUSER_WIDTH];
    assign m_tlast        = w_skid_out[KW+TDATA_WIDTH];
    assign m_tkeep        = w_skid_out[TDATA_WIDTH +: KW];
    assign m_tdata        = w_skid_out[TDATA_WIDTH-1:0];
`else
    assign w_rdy          = m_tready;
    assign m_tvalid       = w_vld;
    assign m_src          = w_sel & ~rst;
    assign m_tdata        = w_data;
    assign m_tkeep        = w_keep;
    assign m_tlast        = w_last;
    assign m_tuser_vendor = w_user;
`endif

endmodule

// File: tb/tb_ofs_fim_axis_arb2.sv
// ---------------------------------------------------------------------------
// tb_ofs_fim_axis_arb2
// Bench for the two-input AXIS arbiter (default build: combinational path).
// Two instances share the sink-side stimulus: u_rr (round-robin) and
// u_fp (fixed priority). use_fp picks whose outputs are observed.
// ---------------------------------------------------------------------------
module tb_ofs_fim_axis_arb2;

    localparam int DW = 64;
    localparam int KW = DW / 8;
    localparam int UW = 10;
    localparam int BW = 1 + UW + KW + DW;

    // ---------------- clock / reset ----------------
    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    logic          s0_tvalid, s0_tlast, s1_tvalid, s1_tlast, m_tready;
    logic [DW-1:0] s0_tdata, s1_tdata;
    logic [KW-1:0] s0_tkeep, s1_tkeep;
    logic [UW-1:0] s0_tuser, s1_tuser;

    logic          a_mvalid, a_s0r, a_s1r, a_mlast, a_src, a_dbg;
    logic [DW-1:0] a_mdata;
    logic [KW-1:0] a_mkeep;
    logic [UW-1:0] a_muser;
    logic          b_mvalid, b_s0r, b_s1r, b_mlast, b_src, b_dbg;
    logic [DW-1:0] b_mdata;
    logic [KW-1:0] b_mkeep;
    logic [UW-1:0] b_muser;

    logic use_fp;
    logic          t_mvalid, t_s0r, t_s1r, t_mlast, t_src, t_dbg;
    logic [DW-1:0] t_mdata;
    logic [KW-1:0] t_mkeep;
    logic [UW-1:0] t_muser;

    assign t_mvalid = use_fp ? b_mvalid : a_mvalid;
    assign t_s0r    = use_fp ? b_s0r    : a_s0r;
    assign t_s1r    = use_fp ? b_s1r    : a_s1r;
    assign t_mlast  = use_fp ? b_mlast  : a_mlast;
    assign t_src    = use_fp ? b_src    : a_src;
    assign t_dbg    = use_fp ? b_dbg    : a_dbg;
    assign t_mdata  = use_fp ? b_mdata  : a_mdata;
    assign t_mkeep  = use_fp ? b_mkeep  : a_mkeep;
    assign t_muser  = use_fp ? b_muser  : a_muser;

    ofs_fim_axis_arb2 #(.TDATA_WIDTH(DW), .TUSER_WIDTH(UW), .PRIO_MODE(0)) u_rr (
        .clk(clk), .rst(rst),
        .s0_tvalid(s0_tvalid), .s0_tready(a_s0r), .s0_tdata(s0_tdata), .s0_tkeep(s0_tkeep),
        .s0_tlast(s0_tlast), .s0_tuser_vendor(s0_tuser),
        .s1_tvalid(s1_tvalid), .s1_tready(a_s1r), .s1_tdata(s1_tdata), .s1_tkeep(s1_tkeep),
        .s1_tlast(s1_tlast), .s1_tuser_vendor(s1_tuser),
        .m_tvalid(a_mvalid), .m_tready(m_tready), .m_tdata(a_mdata), .m_tkeep(a_mkeep),
        .m_tlast(a_mlast), .m_tuser_vendor(a_muser), .m_src(a_src), .o_dbg_state(a_dbg));

    ofs_fim_axis_arb2 #(.TDATA_WIDTH(DW), .TUSER_WIDTH(UW), .PRIO_MODE(1)) u_fp (
        .clk(clk), .rst(rst),
        .s0_tvalid(s0_tvalid), .s0_tready(b_s0r), .s0_tdata(s0_tdata), .s0_tkeep(s0_tkeep),
        .s0_tlast(s0_tlast), .s0_tuser_vendor(s0_tuser),
        .s1_tvalid(s1_tvalid), .s1_tready(b_s1r), .s1_tdata(s1_tdata), .s1_tkeep(s1_tkeep),
        .s1_tlast(s1_tlast), .s1_tuser_vendor(s1_tuser),
        .m_tvalid(b_mvalid), .m_tready(m_tready), .m_tdata(b_mdata), .m_tkeep(b_mkeep),
        .m_tlast(b_mlast), .m_tuser_vendor(b_muser), .m_src(b_src), .o_dbg_state(b_dbg));

    // ---------------- scoreboard bookkeeping ----------------
    int n_vec = 0;
    int n_err = 0;
    logic [BW-1:0] exp_q0[$];
    logic [BW-1:0] exp_q1[$];

    task automatic chk(input string nm, input logic [DW-1:0] act, input logic [DW-1:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", nm, act, exp, $time);
        end
    endtask

    // ---------------- driver tasks ----------------
    task automatic drive(input logic v0, input logic l0, input logic [DW-1:0] d0,
                         input logic v1, input logic l1, input logic [DW-1:0] d1,
                         input logic mr);
        s0_tvalid = v0; s0_tlast = l0; s0_tdata = d0;
        s1_tvalid = v1; s1_tlast = l1; s1_tdata = d1;
        s0_tkeep = KW'($urandom); s1_tkeep = KW'($urandom);
        s0_tuser = UW'($urandom); s1_tuser = UW'($urandom);
        m_tready = mr;
    endtask

    task automatic do_reset();
        @(negedge clk);
        rst = 1'b1;
        drive(1'b1, 1'b0, '0, 1'b1, 1'b0, '0, 1'b1);
        #1;
        chk("rst_mvalid", t_mvalid, 0);
        chk("rst_s0_tready", t_s0r, 0);
        chk("rst_s1_tready", t_s1r, 0);
        chk("rst_m_src", t_src, 0);
        @(negedge clk);
        drive(1'b0, 1'b0, '0, 1'b0, 1'b0, '0, 1'b1);
        rst = 1'b0;
        #1;
        chk("rst_state_idle", t_dbg, 0);
    endtask

    // ---------------- directed table ----------------
    // Bits: {s0v, s0l, s1v, s1l, m_tready, exp_mvalid, exp_src, exp_s0r, exp_s1r}
    typedef struct packed {
        logic s0v, s0l, s1v, s1l, mr;
        logic ev, es, e0r, e1r;
    } vec_t;

    vec_t tbl[19];

    task automatic run_table();
        logic [DW-1:0] d0, d1;
        tbl[0]  = 9'b10001_1010;  // p0 3-beat alone
        tbl[1]  = 9'b10001_1010;
        tbl[2]  = 9'b11001_1010;
        tbl[3]  = 9'b10101_1101;  // both 2-beat: last grant was p0 -> p1
        tbl[4]  = 9'b10111_1101;
        tbl[5]  = 9'b10101_1010;
        tbl[6]  = 9'b11101_1010;
        tbl[7]  = 9'b10101_1101;
        tbl[8]  = 9'b10111_1101;
        tbl[9]  = 9'b00110_1100;  // p1 stalled first beat locks grant
        tbl[10] = 9'b11110_1100;
        tbl[11] = 9'b11111_1101;
        tbl[12] = 9'b11111_1010;  // single-beat alternation
        tbl[13] = 9'b11111_1101;
        tbl[14] = 9'b00001_0010;  // nothing valid: default port = !last_gnt
        tbl[15] = 9'b00101_1101;
        tbl[16] = 9'b10001_0101;  // p1 idles mid-packet, p0 blocked
        tbl[17] = 9'b11111_1101;
        tbl[18] = 9'b11001_1010;
        for (int i = 0; i < 19; i++) begin
            @(negedge clk);
            d0 = {32'h0000_a000, 32'(i)};
            d1 = {32'h0000_b000, 32'(i)};
            drive(tbl[i].s0v, tbl[i].s0l, d0, tbl[i].s1v, tbl[i].s1l, d1, tbl[i].mr);
            #1;
            chk($sformatf("tbl%0d_mvalid", i), t_mvalid, tbl[i].ev);
            chk($sformatf("tbl%0d_m_src", i), t_src, tbl[i].es);
            chk($sformatf("tbl%0d_s0_tready", i), t_s0r, tbl[i].e0r);
            chk($sformatf("tbl%0d_s1_tready", i), t_s1r, tbl[i].e1r);
            if (tbl[i].ev) begin
                chk($sformatf("tbl%0d_tdata", i), t_mdata, tbl[i].es ? d1 : d0);
                chk($sformatf("tbl%0d_tlast", i), t_mlast, tbl[i].es ? tbl[i].s1l : tbl[i].s0l);
            end
        end
    endtask

    // ---------------- randomized run with reference model ----------------
    logic          pv[2], fired[2], pl[2];
    int            rem[2];
    logic [DW-1:0] pd[2];
    logic [KW-1:0] pk[2];
    logic [UW-1:0] pu[2];

    task automatic run_random(input logic fp, input int ncyc);
        int owner;       // port holding the packet lock, -1 when free
        int last_win;    // port that completed the previous packet
        int sel;
        logic exp_v, mr;
        logic [BW-1:0] got, want;
        use_fp = fp;
        do_reset();
        exp_q0.delete(); exp_q1.delete();
        for (int p = 0; p < 2; p++) begin pv[p] = 0; fired[p] = 0; rem[p] = 0; end
        owner = -1; last_win = 1;
        for (int c = 0; c < ncyc; c++) begin
            @(negedge clk);
            for (int p = 0; p < 2; p++) begin
                if (pv[p] && fired[p]) pv[p] = 1'b0;
                if (!pv[p] && $urandom_range(0, 9) < 7) begin
                    if (rem[p] == 0) rem[p] = $urandom_range(1, 4);
                    rem[p]--;
                    pd[p] = {$urandom, $urandom};
                    pk[p] = KW'($urandom);
                    pu[p] = UW'($urandom);
                    pl[p] = (rem[p] == 0);
                    if (p == 0) exp_q0.push_back({pl[p], pu[p], pk[p], pd[p]});
                    else        exp_q1.push_back({pl[p], pu[p], pk[p], pd[p]});
                    pv[p] = 1'b1;
                end
            end
            mr = ($urandom_range(0, 3) != 0);
            s0_tvalid = pv[0]; s0_tlast = pl[0]; s0_tdata = pd[0]; s0_tkeep = pk[0]; s0_tuser = pu[0];
            s1_tvalid = pv[1]; s1_tlast = pl[1]; s1_tdata = pd[1]; s1_tkeep = pk[1]; s1_tuser = pu[1];
            m_tready = mr;
            #1;
            if (owner >= 0)               sel = owner;
            else if (fp && pv[0])         sel = 0;
            else if (fp && pv[1])         sel = 1;
            else if (pv[0] && pv[1])      sel = 1 - last_win;
            else if (pv[0])               sel = 0;
            else if (pv[1])               sel = 1;
            else                          sel = 1 - last_win;
            exp_v = pv[sel];
            chk("rnd_mvalid", t_mvalid, exp_v);
            chk("rnd_m_src", t_src, sel[0]);
            chk("rnd_s0_tready", t_s0r, (sel == 0) && mr);
            chk("rnd_s1_tready", t_s1r, (sel == 1) && mr);
            if (t_mvalid && mr) begin
                got = {t_mlast, t_muser, t_mkeep, t_mdata};
                if ((sel == 0 && exp_q0.size() == 0) || (sel == 1 && exp_q1.size() == 0)) begin
                    n_vec++; n_err++;
                    $display("FAIL rnd_beat: output beat %0h with empty expected queue", got);
                end else begin
                    want = (sel == 0) ? exp_q0.pop_front() : exp_q1.pop_front();
                    chk("rnd_beat_lo", got[DW-1:0], want[DW-1:0]);
                    chk("rnd_beat_hi", DW'(got[BW-1:DW]), DW'(want[BW-1:DW]));
                end
            end
            fired[0] = pv[0] && t_s0r;
            fired[1] = pv[1] && t_s1r;
            if (exp_v && mr && pl[sel]) begin
                owner = -1;
                last_win = sel;
            end else if (owner < 0 && exp_v) begin
                owner = sel;
            end
        end
    endtask

    // ---------------- test sequence ----------------
    initial begin
        rst = 1'b1;
        use_fp = 1'b0;
        drive(1'b0, 1'b0, '0, 1'b0, 1'b0, '0, 1'b0);

        // Directed table on the round-robin instance.
        do_reset();
        run_table();

        // Port 0 first beat stalled 4 cycles with port 1 waiting.
        do_reset();
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            drive(1'b1, 1'b0, 64'hd0, 1'b1, 1'b1, 64'hd1, 1'b0);
            #1;
            chk("stall_tdata", t_mdata, 64'hd0);
            chk("stall_m_src", t_src, 0);
            chk("stall_s1_tready", t_s1r, 0);
        end
        @(negedge clk);
        drive(1'b1, 1'b0, 64'hd0, 1'b1, 1'b1, 64'hd1, 1'b1);
        #1;
        chk("stall_accept_s0_tready", t_s0r, 1);
        @(negedge clk);
        drive(1'b1, 1'b1, 64'hd2, 1'b1, 1'b1, 64'hd1, 1'b1);
        #1;
        chk("stall_beat2_tdata", t_mdata, 64'hd2);
        @(negedge clk);
        drive(1'b0, 1'b0, '0, 1'b1, 1'b1, 64'hd1, 1'b1);
        #1;
        chk("stall_then_p1_src", t_src, 1);
        chk("stall_then_p1_tdata", t_mdata, 64'hd1);

        // Port 0 idles for 3 cycles after beat 2 of 4; port 1 stays blocked.
        do_reset();
        for (int i = 0; i < 9; i++) begin
            @(negedge clk);
            case (i)
                0, 1:    drive(1'b1, 1'b0, 64'(16 + i), 1'b1, 1'b1, 64'he1, 1'b1);
                2, 3, 4: drive(1'b0, 1'b0, '0, 1'b1, 1'b1, 64'he1, 1'b1);
                5:       drive(1'b1, 1'b0, 64'd18, 1'b1, 1'b1, 64'he1, 1'b1);
                6:       drive(1'b1, 1'b1, 64'd19, 1'b1, 1'b1, 64'he1, 1'b1);
                default: drive(1'b0, 1'b0, '0, 1'b1, 1'b1, 64'he1, 1'b1);
            endcase
            #1;
            if (i >= 2 && i <= 4) begin
                chk("drop_mvalid", t_mvalid, 0);
                chk("drop_s1_tready", t_s1r, 0);
            end else if (i <= 6) begin
                chk("drop_p0_src", t_src, 0);
                chk("drop_p0_tdata", t_mdata, 64'(16 + (i < 2 ? i : i - 3)));
            end else begin
                chk("drop_p1_src", t_src, 1);
                chk("drop_p1_s1_tready", t_s1r, 1);
            end
        end

        // Reset in the middle of a port 1 packet.
        do_reset();
        @(negedge clk);
        drive(1'b0, 1'b0, '0, 1'b1, 1'b0, 64'hf1, 1'b1);
        #1;
        chk("rstmid_p1_src", t_src, 1);
        @(negedge clk);
        rst = 1'b1;
        drive(1'b1, 1'b0, 64'hf0, 1'b1, 1'b0, 64'hf2, 1'b1);
        #1;
        chk("rstmid_mvalid", t_mvalid, 0);
        chk("rstmid_s0_tready", t_s0r, 0);
        chk("rstmid_s1_tready", t_s1r, 0);
        chk("rstmid_m_src", t_src, 0);
        @(negedge clk);
        rst = 1'b0;
        drive(1'b1, 1'b1, 64'hf0, 1'b1, 1'b0, 64'hf2, 1'b1);
        #1;
        chk("rstmid_after_src", t_src, 0);
        chk("rstmid_after_tdata", t_mdata, 64'hf0);

        // Fixed priority: port 0 always wins while valid.
        use_fp = 1'b1;
        do_reset();
        for (int i = 0; i < 6; i++) begin
            @(negedge clk);
            drive(1'b1, 1'b1, 64'(32 + i), 1'b1, 1'b1, 64'h99, 1'b1);
            #1;
            chk("fp_src", t_src, 0);
            chk("fp_s1_tready", t_s1r, 0);
            chk("fp_tdata", t_mdata, 64'(32 + i));
        end
        @(negedge clk);
        drive(1'b0, 1'b1, '0, 1'b1, 1'b1, 64'h99, 1'b1);
        #1;
        chk("fp_only_p1_src", t_src, 1);

        // Randomized traffic against the reference model, both policies.
        run_random(1'b0, 3000);
        run_random(1'b1, 2000);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
